// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Holds the FSM state encoding, RISC-V funct3 size/sign constants and the
// store lane helpers (byte enables and lane-replicated write data).
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_t;

    // Unsigned variants exist only for loads; anything undefined is a word.
    function automatic access_size_t access_size(input logic [2:0] funct3, input logic is_store);
        access_size_t sz;
        sz = SZ_W;
        if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) begin
            sz = SZ_B;
        end else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) begin
            sz = SZ_H;
        end
        return sz;
    endfunction

    function automatic logic [3:0] store_be(input access_size_t sz, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << addr_lo;
            SZ_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input access_size_t sz, input logic [31:0] wdata);
        logic [31:0] data;
        case (sz)
            SZ_B:    data = {4{wdata[7:0]}};
            SZ_H:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Signals: bus_req/bus_we/bus_addr/bus_be/bus_wdata driven by the master,
// bus_ready/bus_rdata returned by the slave (rdata valid while ready=1).
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ready;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/load_store_unit_formatter.sv
// Load data formatter: selects the addressed byte/halfword lane of the raw
// bus word and sign- or zero-extends it according to funct3.
// Ports: raw (bus word), addr_lo (byte offset), funct3, data (result).
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        data     = raw;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Takes a load/store from EX/MEM, runs one
// valid/ready transaction on the data bus, stalls the pipeline meanwhile
// and presents formatted load data for MEM/WB on the done pulse.
// Ports: clk, reset (async, active-high); in_mem_read/in_mem_write/
// in_funct3/in_addr/in_wdata from EX/MEM; out_read_data, out_stall (comb),
// out_done, out_bus_err to the pipeline; bus (load_store_unit_if.master).
// Build option MISALIGN_TRAP_EN: adds out_misaligned and traps misaligned
// halfword/word accesses without touching the bus.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic [31:0]       out_read_data,
    output logic              out_stall,
    output logic              out_done,
    output logic              out_bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic              out_misaligned,
`endif
    load_store_unit_if.master bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]   q_addr_lo;
    logic [2:0]   q_funct3;
    logic         q_we;

    logic         req;
    logic         is_store;
    access_size_t sz;
    logic [31:0]  fmt_data;
`ifdef MISALIGN_TRAP_EN
    logic         misaligned;
`endif

    // Request decode; a simultaneous read and write is treated as a read.
    always_comb begin
        req      = in_mem_read | in_mem_write;
        is_store = ~in_mem_read & in_mem_write;
        sz       = access_size(in_funct3, is_store);
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = ((sz == SZ_H) && in_addr[0]) || ((sz == SZ_W) && (in_addr[1:0] != 2'b00));
    end
`endif

    // Stall covers the accepting IDLE cycle and every REQ cycle; released in DONE.
    always_comb begin
        out_stall = ~reset & (((state == IDLE) & req) | (state == REQ));
    end

    load_formatter u_formatter (
        .raw     (bus.bus_rdata),
        .addr_lo (q_addr_lo),
        .funct3  (q_funct3),
        .data    (fmt_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            q_addr_lo     <= '0;
            q_funct3      <= '0;
            q_we          <= 1'b0;
            out_read_data <= '0;
            out_done      <= 1'b0;
            out_bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            out_misaligned <= 1'b0;
`endif
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_done    <= 1'b0;
                    out_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    out_misaligned <= 1'b0;
`endif
                    cnt <= '0;
                    if (req) begin
                        q_addr_lo     <= in_addr[1:0];
                        q_funct3      <= in_funct3;
                        q_we          <= is_store;
                        bus.bus_we    <= is_store;
                        bus.bus_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                        bus.bus_be    <= is_store ? store_be(sz, in_addr[1:0]) : 4'b1111;
                        bus.bus_wdata <= store_data(sz, in_wdata);
`ifdef MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state          <= DONE;
                            out_done       <= 1'b1;
                            out_misaligned <= 1'b1;
                            out_read_data  <= '0;
                        end else begin
                            state       <= REQ;
                            bus.bus_req <= 1'b1;
                        end
`else
                        state       <= REQ;
                        bus.bus_req <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    // A completion on the last allowed cycle still wins over the timeout.
                    if (bus.bus_ready) begin
                        state         <= DONE;
                        bus.bus_req   <= 1'b0;
                        out_done      <= 1'b1;
                        out_read_data <= q_we ? 32'd0 : fmt_data;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        bus.bus_req   <= 1'b0;
                        out_done      <= 1'b1;
                        out_bus_err   <= 1'b1;
                        out_read_data <= '0;
                    end
                end
                DONE: begin
                    // Inputs are ignored here: the pipeline advances on this edge.
                    state       <= IDLE;
                    cnt         <= '0;
                    out_done    <= 1'b0;
                    out_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    out_misaligned <= 1'b0;
`endif
                end
                default: begin
                    state       <= IDLE;
                    bus.bus_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-level
// reference model of lane selection, extension, enables and latency.
module tb_load_store_unit;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] out_read_data;
    logic        out_stall;
    logic        out_done;
    logic        out_bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        out_misaligned;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    load_store_unit_if #(.ADDR_W(32)) bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .out_read_data (out_read_data),
        .out_stall     (out_stall),
        .out_done      (out_done),
        .out_bus_err   (out_bus_err),
`ifdef MISALIGN_TRAP_EN
        .out_misaligned(out_misaligned),
`endif
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access width in bytes; unsigned encodings are loads only, the rest are words.
    function automatic int m_size(input logic [2:0] f3, input logic store);
        if (f3 == 3'd0 || (!store && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!store && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> ((a % 4) * 8)) & 32'hFF;
        h = (raw >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input int sz, input logic store, input logic [31:0] a);
        if (!store || sz == 4) return 32'hF;
        if (sz == 1) return 32'h1 << (a % 4);
        return 32'h3 << (a & 32'h2);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic m_misaligned(input int sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One full access: delay = number of REQ cycles before bus_ready is raised.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] w,
                              input logic [31:0] raw, input int delay);
        logic        store;
        int          sz;
        logic        mis;
        logic        tmo;
        logic [31:0] exp_rd;
        int          exp_n;
        int          n;
        int          req_cycles;
        logic        got_done;

        store  = !rd && wr;
        sz     = m_size(f3, store);
        mis    = m_misaligned(sz, a);
        tmo    = !mis && (delay >= int'(T));
        exp_rd = (mis || tmo || store) ? 32'd0 : m_load(f3, a, raw);
        exp_n  = mis ? 1 : (tmo ? int'(T) + 1 : delay + 2);

        @(negedge clk);
        in_mem_read  = rd;
        in_mem_write = wr;
        in_funct3    = f3;
        in_addr      = a;
        in_wdata     = w;
        bus_if.bus_ready = 1'b0;
        #1 check("stall_accept", 32'(out_stall), 32'd1);

        n = 0;
        req_cycles = 0;
        got_done = 1'b0;
        while (!got_done && n < 40) begin
            @(negedge clk);
            n++;
            if (out_done) begin
                got_done = 1'b1;
            end else begin
                if (bus_if.bus_req) req_cycles++;
                if (n == 1) begin
                    check("bus_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
                    check("bus_we", 32'(bus_if.bus_we), 32'(store));
                    check("bus_be", 32'(bus_if.bus_be), m_be(sz, store, a));
                    if (store) check("bus_wdata", bus_if.bus_wdata, m_wdata(sz, w));
                end
                check("stall_busy", 32'(out_stall), 32'd1);
                bus_if.bus_ready = (n - 1 == delay);
                bus_if.bus_rdata = (n - 1 == delay) ? raw : $urandom;
            end
        end
        bus_if.bus_ready = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;

        check("done_seen", 32'(got_done), 32'd1);
        check("latency", n, exp_n);
        check("req_cycles", req_cycles, mis ? 0 : (tmo ? int'(T) : delay + 1));
        check("read_data", out_read_data, exp_rd);
        check("bus_err", 32'(out_bus_err), 32'(tmo));
        check("stall_done", 32'(out_stall), 32'd0);
        check("req_done", 32'(bus_if.bus_req), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("misaligned", 32'(out_misaligned), 32'(mis));
`endif
        @(negedge clk);
        check("done_pulse", 32'(out_done), 32'd0);
        check("read_hold", out_read_data, exp_rd);
    endtask

    initial begin
        reset = 1'b1;
        in_mem_read = 1'b0;
        in_mem_write = 1'b0;
        in_funct3 = '0;
        in_addr = '0;
        in_wdata = '0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = '0;

        #1;
        check("rst_read_data", out_read_data, 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_err", 32'(out_bus_err), 32'd0);
        check("rst_stall", 32'(out_stall), 32'd0);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_be", 32'(bus_if.bus_be), 32'd0);
        check("rst_addr", bus_if.bus_addr, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_1234, 1);
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'd0, 0);
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h1234_5678, 10);
        run_access(1'b1, 1'b0, 3'b101, 32'h302, 32'd0, 32'h9876_5432, int'(T) - 1);
        run_access(1'b1, 1'b1, 3'b001, 32'h042, 32'h5555_5555, 32'hC0DE_8001, 2);

        // Reset while the request is outstanding
        @(negedge clk);
        in_mem_read = 1'b1;
        in_funct3 = 3'b010;
        in_addr = 32'h400;
        @(negedge clk);
        check("abort_req_before", 32'(bus_if.bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_req", 32'(bus_if.bus_req), 32'd0);
        check("abort_stall", 32'(out_stall), 32'd0);
        in_mem_read = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(out_done), 32'd0);
        reset = 1'b0;
        run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 32'hCAFE_F00D, 0);

        // Word at an unaligned address: trapped or treated as aligned depending on build
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'h0BAD_F00D, 0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic rd;
            logic wr;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            run_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
